// File: rtl/detector_jogada.sv
// Debounced key-press detector: 2-flop synchronizer, stability filter and release wait.
// Define DETECTOR_JOGADA_INVALIDA_EN to flag non-one-hot captures on jogada_invalida.
module detector_jogada #(
  parameter int unsigned DEBOUNCE_CICLOS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] chaves,
  input  logic       habilita,
  input  logic       limpa,
  output logic [3:0] jogada,
  output logic       jogada_feita,
  output logic       tem_jogada,
  output logic       jogada_invalida,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    StOcioso     = 4'd0,
    StFiltrando  = 4'd1,
    StCapturado  = 4'd2,
    StEsperaSolt = 4'd3
  } estado_t;

  localparam logic [3:0] CntAlvo = 4'(DEBOUNCE_CICLOS - 1);

  estado_t    estado_q, estado_d;
  logic [3:0] sinc_q, s_q;
  logic [3:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0] jogada_q, jogada_d;
  logic       tem_q, tem_d;
  logic       captura;
  logic       valida;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sinc_q <= 4'b0000;
      s_q    <= 4'b0000;
    end else begin
      sinc_q <= chaves;
      s_q    <= sinc_q;
    end
  end

  assign cnt_inc = (cnt_q == 4'hf) ? cnt_q : cnt_q + 4'd1;

`ifdef DETECTOR_JOGADA_INVALIDA_EN
  assign valida = $onehot(cand_q);
`else
  assign valida = 1'b1;
`endif

  always_comb begin
    estado_d = estado_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    captura  = 1'b0;
    unique case (estado_q)
      StOcioso: begin
        if (s_q != 4'b0000 && habilita) begin
          cand_d   = s_q;
          cnt_d    = 4'd1;
          estado_d = StFiltrando;
        end
      end
      StFiltrando: begin
        if (s_q == 4'b0000) begin
          cnt_d    = 4'd0;
          estado_d = StOcioso;
        end else if (s_q != cand_q) begin
          cand_d = s_q;
          cnt_d  = 4'd1;
        end else if (cnt_q == CntAlvo) begin
          captura  = 1'b1;
          estado_d = StCapturado;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StCapturado: begin
        cnt_d    = 4'd0;
        estado_d = StEsperaSolt;
      end
      StEsperaSolt: begin
        // cnt counts consecutive released samples; any bounce restarts it
        if (s_q != 4'b0000) begin
          cnt_d = 4'd0;
        end else if (cnt_q >= CntAlvo) begin
          cnt_d    = 4'd0;
          estado_d = StOcioso;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d    = 4'd0;
        estado_d = StOcioso;
      end
    endcase
  end

  // A capture edge takes priority over limpa, even when the capture is rejected.
  always_comb begin
    jogada_d = jogada_q;
    tem_d    = tem_q;
    if (captura) begin
      if (valida) begin
        jogada_d = cand_q;
        tem_d    = 1'b1;
      end
    end else if (limpa) begin
      jogada_d = 4'b0000;
      tem_d    = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= StOcioso;
      cand_q   <= 4'b0000;
      cnt_q    <= 4'd0;
      jogada_q <= 4'b0000;
      tem_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      jogada_q <= jogada_d;
      tem_q    <= tem_d;
    end
  end

  assign jogada       = jogada_q;
  assign tem_jogada   = tem_q;
  assign db_estado    = estado_q;
  assign jogada_feita = (estado_q == StCapturado) && valida;

`ifdef DETECTOR_JOGADA_INVALIDA_EN
  assign jogada_invalida = (estado_q == StCapturado) && !valida;
`else
  assign jogada_invalida = 1'b0;
`endif

endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada: directed scenarios plus random key activity against a
// cycle model built from the press/filter/release rules.
module tb_detector_jogada;

  localparam int D = 3;
`ifdef DETECTOR_JOGADA_INVALIDA_EN
  localparam bit InvEn = 1'b1;
`else
  localparam bit InvEn = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] chaves = 4'b0000;
  logic       habilita = 1'b0;
  logic       limpa = 1'b0;
  logic [3:0] jogada;
  logic       jogada_feita;
  logic       tem_jogada;
  logic       jogada_invalida;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  int n_feita = 0;
  int n_inv = 0;

  detector_jogada #(.DEBOUNCE_CICLOS(D)) dut (
    .clock          (clock),
    .reset          (reset),
    .chaves         (chaves),
    .habilita       (habilita),
    .limpa          (limpa),
    .jogada         (jogada),
    .jogada_feita   (jogada_feita),
    .tem_jogada     (tem_jogada),
    .jogada_invalida(jogada_invalida),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sample pipeline as a 2-deep delay line, phase as a plain integer.
  int m_phase, m_cnt, m_cand, m_jog, m_tem, m_feita, m_inv, m_d1, m_d2;

  task automatic model_step();
    int s;
    bit entra;
    if (reset) begin
      m_phase = 0; m_cnt = 0; m_cand = 0; m_jog = 0; m_tem = 0;
      m_feita = 0; m_inv = 0; m_d1 = 0; m_d2 = 0;
      return;
    end
    s = m_d2;
    entra = 1'b0;
    m_feita = 0;
    m_inv = 0;
    if (m_phase == 0) begin
      if (s != 0 && habilita) begin m_cand = s; m_cnt = 1; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (s == 0) m_phase = 0;
      else if (s != m_cand) begin m_cand = s; m_cnt = 1; end
      else if (m_cnt + 1 >= D) entra = 1'b1;
      else m_cnt++;
    end else if (m_phase == 2) begin
      m_phase = 3; m_cnt = 0;
    end else begin
      if (s != 0) m_cnt = 0;
      else if (m_cnt + 1 >= D) begin m_phase = 0; m_cnt = 0; end
      else m_cnt++;
    end
    if (entra) begin
      m_phase = 2;
      if (!InvEn || $countones(m_cand) == 1) begin
        m_jog = m_cand; m_tem = 1; m_feita = 1;
      end else begin
        m_inv = 1;
      end
    end else if (limpa) begin
      m_jog = 0; m_tem = 0;
    end
    m_d2 = m_d1;
    m_d1 = int'(chaves);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      model_step();
      #2;
      chk("jogada", int'(jogada), m_jog);
      chk("tem_jogada", int'(tem_jogada), m_tem);
      chk("jogada_feita", int'(jogada_feita), m_feita);
      chk("jogada_invalida", int'(jogada_invalida), m_inv);
      chk("db_estado", int'(db_estado), m_phase);
    end
  end

  // Drive inputs for one cycle, then observe just after the following rising edge.
  task automatic tick(input logic [3:0] ch, input logic h, input logic l);
    chaves = ch;
    habilita = h;
    limpa = l;
    @(posedge clock);
    #3;
    n_feita += int'(jogada_feita);
    n_inv += int'(jogada_invalida);
  endtask

  task automatic hold(input logic [3:0] ch, input int n);
    for (int i = 0; i < n; i++) tick(ch, 1'b1, 1'b0);
  endtask

  initial begin
    int exp_db[10];
    int k;
    exp_db = '{0, 0, 1, 1, 2, 3, 3, 3, 3, 3};

    @(posedge clock);
    #3;
    chk("reset_jogada", int'(jogada), 0);
    chk("reset_estado", int'(db_estado), 0);
    chk("reset_feita", int'(jogada_feita), 0);
    reset = 1'b0;

    // Basic press: pulse in the cycle after the 5th edge.
    n_feita = 0;
    for (int i = 0; i < 10; i++) begin
      tick(4'b0001, 1'b1, 1'b0);
      chk("press_estado_seq", int'(db_estado), exp_db[i]);
      chk("press_pulse_seq", int'(jogada_feita), (i == 4) ? 1 : 0);
    end
    chk("press_jogada", int'(jogada), 1);
    chk("press_tem", int'(tem_jogada), 1);
    hold(4'b0000, 6);
    chk("release_estado", int'(db_estado), 0);

    // Too short to pass the filter.
    n_feita = 0; n_inv = 0;
    hold(4'b0010, 2);
    hold(4'b0000, 5);
    chk("short_pulses", n_feita + n_inv, 0);
    chk("short_jogada", int'(jogada), 1);
    chk("short_estado", int'(db_estado), 0);

    // Two keys at once.
    n_feita = 0; n_inv = 0;
    hold(4'b0101, 6);
    chk("multi_feita", n_feita, InvEn ? 0 : 1);
    chk("multi_inv", n_inv, InvEn ? 1 : 0);
    chk("multi_jogada", int'(jogada), InvEn ? 1 : 5);
    hold(4'b0000, 6);

    // Held key waits for habilita; pulse first seen after the 3rd edge with habilita high.
    n_feita = 0;
    for (int i = 0; i < 6; i++) tick(4'b1000, 1'b0, 1'b0);
    chk("hab_blocked", n_feita, 0);
    chk("hab_blocked_estado", int'(db_estado), 0);
    k = 0;
    for (int i = 1; i <= 10 && k == 0; i++) begin
      tick(4'b1000, 1'b1, 1'b0);
      if (jogada_feita) k = i;
    end
    chk("hab_edges_to_pulse", k, 3);
    chk("hab_jogada", int'(jogada), 8);
    hold(4'b0000, 6);

    // limpa alone, then limpa on the capture edge.
    tick(4'b0000, 1'b1, 1'b1);
    chk("limpa_jogada", int'(jogada), 0);
    chk("limpa_tem", int'(tem_jogada), 0);
    hold(4'b0010, 4);
    tick(4'b0010, 1'b1, 1'b1);
    chk("limpa_vs_capture_jogada", int'(jogada), 2);
    chk("limpa_vs_capture_tem", int'(tem_jogada), 1);
    hold(4'b0000, 6);

    // Release bounce keeps the FSM waiting until three clean zeros.
    hold(4'b0001, 6);
    n_feita = 0;
    hold(4'b0000, 2);
    hold(4'b0001, 1);
    hold(4'b0000, 4);
    chk("bounce_still_waiting", int'(db_estado), 3);
    hold(4'b0000, 1);
    chk("bounce_done", int'(db_estado), 0);
    chk("bounce_no_pulse", n_feita, 0);

    // Reset mid-filter aborts; capture restarts from scratch.
    hold(4'b0100, 3);
    chk("pre_reset_estado", int'(db_estado), 1);
    reset = 1'b1;
    #1;
    chk("async_reset_estado", int'(db_estado), 0);
    chk("async_reset_jogada", int'(jogada), 0);
    chk("async_reset_tem", int'(tem_jogada), 0);
    hold(4'b0100, 2);
    reset = 1'b0;
    k = 0;
    for (int i = 1; i <= 10 && k == 0; i++) begin
      tick(4'b0100, 1'b1, 1'b0);
      if (jogada_feita) k = i;
    end
    chk("post_reset_edges", k, 5);
    chk("post_reset_jogada", int'(jogada), 4);
    hold(4'b0000, 6);

    // Random key activity with occasional limpa and reset.
    for (int n = 0; n < 120; n++) begin
      logic [3:0] pat;
      int sel, dur;
      logic h;
      sel = $urandom_range(0, 9);
      if (sel < 4) pat = 4'b0000;
      else if (sel < 8) pat = 4'(1 << $urandom_range(0, 3));
      else pat = 4'($urandom_range(1, 15));
      dur = $urandom_range(1, 8);
      h = ($urandom_range(0, 9) != 0);
      for (int j = 0; j < dur; j++) begin
        reset = ($urandom_range(0, 149) == 0);
        tick(pat, h, ($urandom_range(0, 19) == 0));
      end
    end
    reset = 1'b0;
    hold(4'b0000, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
